// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response bus between the cache (master) and the memory responder (slave).
interface mem_responder_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NBYTES = 4;

  logic                           mem_req;
  logic [ADDR_W-1:0]              mem_addr;
  logic                           mem_write_en;
  logic [0:NBYTES-1][BYTE_W-1:0]  mem_data_in;
  logic                           mem_ready;
  logic                           mem_done;
  logic [0:NBYTES-1][BYTE_W-1:0]  mem_data_out;

  modport master (
    output mem_req, mem_addr, mem_write_en, mem_data_in,
    input  mem_ready, mem_done, mem_data_out
  );

  modport slave (
    input  mem_req, mem_addr, mem_write_en, mem_data_in,
    output mem_ready, mem_done, mem_data_out
  );
endinterface

// File: rtl/mem_responder.sv
// Word-wide main-memory responder with a programmable access latency and one-cycle done pulse.
module mem_responder #(
  parameter int unsigned WORD_AW = 10,
  parameter int unsigned LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  mem_responder_if.slave  bus
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MEM_WORDS = 2 ** WORD_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_accept;
  logic                   w_rd_we;
  logic [WORD_AW-1:0]     w_rd_idx;
  logic                   w_load_rd;
  logic                   w_fwd;
  logic [0:3][7:0]        w_rd_word;

  logic [WORD_AW-1:0]     r_idx;
  logic                   r_we;
  logic [0:3][7:0]        r_wdata;
  logic                   r_ready;
  logic                   r_done;
  logic [0:3][7:0]        r_data_out;

  logic [0:3][7:0]        r_mem [0:MEM_WORDS-1];

  logic [WORD_AW-1:0]     w_idx;
  logic                   w_unused_addr;

  assign w_idx         = bus.mem_addr[WORD_AW+1:2];
  assign w_unused_addr = ^{bus.mem_addr[31:WORD_AW+2], bus.mem_addr[1:0]};

  // Next state, counter and acceptance; a new request may be taken in IDLE or in the DONE cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_state_next = IDLE;
        if (bus.mem_req) begin
          w_accept     = 1'b1;
          w_cnt_next   = CNT_W'(LATENCY - 1);
          w_state_next = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Read sampling for the operation entering DONE, with bypass of a write committing at the same edge.
  always_comb begin
    w_rd_we   = w_accept ? bus.mem_write_en : r_we;
    w_rd_idx  = w_accept ? w_idx : r_idx;
    w_load_rd = (w_state_next == DONE) && !w_rd_we;
    w_fwd     = (r_state == DONE) && r_we && (r_idx == w_rd_idx);
    w_rd_word = w_fwd ? r_wdata : r_mem[w_rd_idx];
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ready <= (w_state_next != BUSY);
      r_done  <= (w_state_next == DONE);
      if (w_load_rd) begin
        r_data_out <= w_rd_word;
      end
    end
  end

  // Request capture; later bus activity while busy is ignored.
  always_ff @(posedge clk) begin
    if (!rst_b && w_accept) begin
      r_idx   <= w_idx;
      r_we    <= bus.mem_write_en;
      r_wdata <= bus.mem_data_in;
    end
  end

  // Write commit at the end of the DONE cycle unless reset aborts it.
  always_ff @(posedge clk) begin
    if (!rst_b && (r_state == DONE) && r_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign bus.mem_ready    = r_ready;
  assign bus.mem_done     = r_done;
  assign bus.mem_data_out = r_data_out;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (latency 4 and 1) on shared stimulus, each against a cycle-count model.
module tb_mem_responder;

  localparam int unsigned AW = 10;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        t_req;
  logic        t_we;
  logic [31:0] t_addr;
  logic [31:0] t_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder_if if4 ();
  mem_responder_if if1 ();

  assign if4.mem_req      = t_req;
  assign if4.mem_addr     = t_addr;
  assign if4.mem_write_en = t_we;
  assign if4.mem_data_in  = t_data;
  assign if1.mem_req      = t_req;
  assign if1.mem_addr     = t_addr;
  assign if1.mem_write_en = t_we;
  assign if1.mem_data_in  = t_data;

  mem_responder #(.WORD_AW(AW), .LATENCY(4)) u_dut4 (.clk(clk), .rst_b(rst_b), .bus(if4.slave));
  mem_responder #(.WORD_AW(AW), .LATENCY(1)) u_dut1 (.clk(clk), .rst_b(rst_b), .bus(if1.slave));

  logic        o_ready [2];
  logic        o_done  [2];
  logic [31:0] o_dout  [2];
  assign o_ready[0] = if4.mem_ready;
  assign o_done[0]  = if4.mem_done;
  assign o_dout[0]  = if4.mem_data_out;
  assign o_ready[1] = if1.mem_ready;
  assign o_done[1]  = if1.mem_done;
  assign o_dout[1]  = if1.mem_data_out;

  // Reference model: an accepted op completes LATENCY edges later; storage is a plain word array.
  int unsigned lat_of [2] = '{4, 1};
  int unsigned ec = 0;
  bit          started = 0;
  bit          m_act   [2];
  int unsigned m_due   [2];
  bit          m_we    [2];
  logic [AW-1:0] m_idx [2];
  logic [31:0] m_dat   [2];
  logic [31:0] m_mem   [2][1024];
  bit          m_kn    [2][1024];
  bit          e_ready [2];
  bit          e_done  [2];
  logic [31:0] e_dout  [2];
  bit          e_known [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_b) begin
        m_act[d]   = 0;
        e_ready[d] = 1;
        e_done[d]  = 0;
        e_dout[d]  = '0;
        e_known[d] = 1;
      end else begin
        if (m_act[d] && (m_due[d] + 1 == ec)) begin
          if (m_we[d]) begin
            m_mem[d][m_idx[d]] = m_dat[d];
            m_kn[d][m_idx[d]]  = 1;
          end
          m_act[d] = 0;
        end
        if (t_req && !m_act[d]) begin
          m_act[d] = 1;
          m_due[d] = ec + lat_of[d] - 1;
          m_we[d]  = t_we;
          m_idx[d] = t_addr[AW+1:2];
          m_dat[d] = t_data;
        end
        e_done[d] = m_act[d] && (m_due[d] == ec);
        if (e_done[d] && !m_we[d]) begin
          e_dout[d]  = m_mem[d][m_idx[d]];
          e_known[d] = m_kn[d][m_idx[d]];
        end
        e_ready[d] = !m_act[d] || e_done[d];
      end
    end
    if (rst_b) started = 1;
    ec++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk(d == 0 ? "ready_L4" : "ready_L1", 32'(o_ready[d]), 32'(e_ready[d]));
        chk(d == 0 ? "done_L4" : "done_L1", 32'(o_done[d]), 32'(e_done[d]));
        if (e_known[d]) chk(d == 0 ? "dout_L4" : "dout_L1", o_dout[d], e_dout[d]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d);
    t_req  = 1'b1;
    t_we   = we;
    t_addr = a;
    t_data = d;
  endtask

  task automatic idle();
    t_req = 1'b0;
  endtask

  // One request on an idle bus with literal expectations on the latency-4 instance.
  task automatic op(input bit we, input logic [31:0] a, input logic [31:0] d,
                    input string nm, input bit chkd, input logic [31:0] ex);
    drive(we, a, d);
    step();
    idle();
    repeat (3) step();
    chk({nm, "_done"}, 32'(if4.mem_done), 32'd1);
    if (chkd) chk({nm, "_data"}, if4.mem_data_out, ex);
    step();
    chk({nm, "_after"}, 32'(if4.mem_done), 32'd0);
  endtask

  logic [31:0] b2b_addr [4] = '{32'h20, 32'h20, 32'h24, 32'h24};
  logic [31:0] b2b_data [4] = '{32'h01020304, 32'h0, 32'hA5A55A5A, 32'h0};
  bit          b2b_we   [4] = '{1, 0, 1, 0};

  initial begin
    int n;
    int unsigned widx;
    rst_b = 1'b1;
    t_req = 1'b0; t_we = 1'b0; t_addr = '0; t_data = '0;

    // Reset held two cycles.
    step(); step();
    rst_b = 1'b0;
    step();
    chk("rst_ready", 32'(if4.mem_ready), 32'd1);
    chk("rst_done", 32'(if4.mem_done), 32'd0);
    chk("rst_dout", if4.mem_data_out, 32'h0);

    // Write then read with word-offset address.
    op(1, 32'h10, 32'hDEADBEEF, "wr10", 0, 0);
    op(0, 32'h12, 32'h0, "rd12", 1, 32'hDEADBEEF);

    // Back-to-back on the latency-1 instance.
    drive(b2b_we[0], b2b_addr[0], b2b_data[0]);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("b2b_done", 32'(if1.mem_done), (k <= 4) ? 32'd1 : 32'd0);
      if (k == 2) chk("b2b_rd20", if1.mem_data_out, 32'h01020304);
      if (k == 4) chk("b2b_rd24", if1.mem_data_out, 32'hA5A55A5A);
      if (k < 4) drive(b2b_we[k], b2b_addr[k], b2b_data[k]);
      else idle();
    end
    repeat (4) step();

    // Request during BUSY is dropped.
    op(1, 32'h0, 32'hCAFEF00D, "wr0", 0, 0);
    drive(0, 32'h0, 32'h0);
    step();
    chk("busy_ready", 32'(if4.mem_ready), 32'd0);
    drive(1, 32'h0, 32'h12345678);
    step();
    idle();
    n = 0;
    repeat (8) begin
      if (if4.mem_done) n++;
      step();
    end
    chk("busy_one_done", 32'(n), 32'd1);
    op(0, 32'h0, 32'h0, "rd0", 1, 32'hCAFEF00D);

    // Reset aborts an in-flight write.
    op(1, 32'h40, 32'h55667788, "wr40", 0, 0);
    drive(1, 32'h40, 32'h11223344);
    step();
    idle();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    chk("abort_done", 32'(if4.mem_done), 32'd0);
    n = 0;
    repeat (8) begin
      if (if4.mem_done) n++;
      step();
    end
    chk("abort_no_done", 32'(n), 32'd0);
    op(0, 32'h40, 32'h0, "rd40", 1, 32'h55667788);

    // Address wrap modulo memory size.
    op(1, 32'h1004, 32'hAABBCCDD, "wr1004", 0, 0);
    op(0, 32'h4, 32'h0, "rd4", 1, 32'hAABBCCDD);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_b  = ($urandom_range(0, 149) == 0);
      t_req  = 1'($urandom_range(0, 1));
      t_we   = 1'($urandom_range(0, 1));
      widx   = $urandom_range(0, 7);
      if (widx == 7) widx = 1023;
      t_addr = ($urandom & 32'hFFFF_F000) | (widx << 2) | ($urandom & 32'h3);
      t_data = $urandom;
      step();
    end
    rst_b = 1'b0;
    idle();
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
